mod_reduce_arbiter: RTL and testbench

MOD_REDUCE_ARBITER -- requirements
Module: mod_reduce_arbiter

---
 rtl/mod_reduce_arbiter.sv | 139 +++++++++++++
 tb/tb_mod_reduce_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_reduce_arbiter.sv
`default_nettype none
// ============================================================================
// mod_reduce_arbiter : round-robin arbiter sharing one modular-reduction unit
// Revision: 1.0
// ============================================================================
module mod_reduce_arbiter #(
  parameter int DATA_WIDTH = 48,
  parameter int Q_WIDTH    = 23,
  parameter int N_REQ      = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [N_REQ*Q_WIDTH-1:0]      req_q,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [$clog2(N_REQ)-1:0]      rsp_id,
  output logic [Q_WIDTH-1:0]            rsp_data,
  output logic                          rsp_err,
  output logic                          red_start,
  output logic [DATA_WIDTH-1:0]         red_data_in,
  output logic [Q_WIDTH-1:0]            red_q,
  input  logic                          red_done,
  input  logic [Q_WIDTH-1:0]            red_data_out
);

  localparam int c_id_w  = $clog2(N_REQ);
  localparam int c_cnt_w = $clog2(TIMEOUT);
  localparam logic [c_id_w-1:0]  c_last_id  = c_id_w'(N_REQ - 1);
  localparam logic [c_id_w:0]    c_n_ext    = (c_id_w + 1)'(N_REQ);
  // Leaving WAIT after this count makes rsp_valid rise TIMEOUT cycles after red_start.
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              r_state;
  logic [c_id_w-1:0]   r_ptr;
  logic [c_cnt_w-1:0]  r_cnt;

  logic                w_gnt_found;
  logic [c_id_w-1:0]   w_gnt_id;
  logic [c_id_w:0]     w_idx;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [Q_WIDTH-1:0]  w_sel_q;

  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_id    = '0;
    w_idx       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = {1'b0, r_ptr} + (c_id_w + 1)'(i);
      if (w_idx >= c_n_ext) w_idx = w_idx - c_n_ext;
      if (!w_gnt_found && req_valid[w_idx[c_id_w-1:0]]) begin
        w_gnt_found = 1'b1;
        w_gnt_id    = w_idx[c_id_w-1:0];
      end
    end
  end

  // Only the granted requester's operand slices reach the capture registers.
  always_comb begin
    w_sel_data = '0;
    w_sel_q    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt_id == c_id_w'(i)) begin
        w_sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_q    = req_q[i*Q_WIDTH +: Q_WIDTH];
      end
    end
  end

  assign req_ready = (rst_n && (r_state == S_IDLE) && w_gnt_found)
                   ? ({{(N_REQ-1){1'b0}}, 1'b1} << w_gnt_id) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_cnt       <= '0;
      red_start   <= 1'b0;
      red_data_in <= '0;
      red_q       <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_found) begin
            red_data_in <= w_sel_data;
            red_q       <= w_sel_q;
            rsp_id      <= w_gnt_id;
            red_start   <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          red_start <= 1'b0;
          r_cnt     <= '0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (red_done) begin
            rsp_data  <= red_data_out;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            r_state   <= S_RESP;
          end else if (r_cnt == c_cnt_last) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            r_state   <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_ptr     <= (rsp_id == c_last_id) ? '0 : rsp_id + 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mod_reduce_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mod_reduce_arbiter : directed self-checking bench for mod_reduce_arbiter
// Revision: 1.0
// ============================================================================
module tb_mod_reduce_arbiter;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    req_valid;
  logic [3:0]    req_ready;
  logic [191:0]  req_data;
  logic [91:0]   req_q;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [22:0]   rsp_data;
  logic          rsp_err;
  logic          red_start;
  logic [47:0]   red_data_in;
  logic [22:0]   red_q;
  logic          red_done;
  logic [22:0]   red_data_out;

  int n_tests = 0;
  int n_fail  = 0;

  mod_reduce_arbiter #(
    .DATA_WIDTH(48), .Q_WIDTH(23), .N_REQ(4), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_q(req_q),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .red_start(red_start), .red_data_in(red_data_in), .red_q(red_q),
    .red_done(red_done), .red_data_out(red_data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output logic [3:0] g);
    int n;
    n = 0;
    #1;
    while (req_ready == 4'b0 && n < 16) begin
      tick();
      #1;
      n++;
    end
    g = req_ready;
    check("grant_seen", 64'(req_ready != 4'b0), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_red"}, 64'({red_start, red_data_in, red_q}), 64'd0);
    check({tag, "_rsp"}, 64'({rsp_valid, rsp_id, rsp_data, rsp_err}), 64'd0);
  endtask

  initial begin
    logic [3:0] g;
    int         n;

    rst_n        = 1'b0;
    req_valid    = 4'b1111;
    rsp_ready    = 1'b1;
    red_done     = 1'b0;
    red_data_out = '0;
    for (int i = 0; i < 4; i++) begin
      req_data[i*48 +: 48] = 48'h1000 + 48'(i);
      req_q[i*23 +: 23]    = 23'h100 + 23'(i);
    end

    // Reset: outputs zero even with every request asserted
    #1;
    check_all_zero("reset");
    repeat (3) tick();
    check_all_zero("reset_hold");
    rst_n = 1'b1;

    // Fairness: all four held high, order 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      wait_grant(g);
      check("fair_grant", 64'(g), 64'(4'b0001 << (k % 4)));
      tick();
      check("fair_start", 64'(red_start), 64'd1);
      check("fair_ready_issue", 64'(req_ready), 64'd0);
      check("fair_data", 64'(red_data_in), 64'h1000 + 64'(k % 4));
      check("fair_q", 64'(red_q), 64'h100 + 64'(k % 4));
      tick();
      red_done     = 1'b1;
      red_data_out = 23'(100 + k);
      tick();
      red_done = 1'b0;
      if (k == 4) req_valid = 4'b0000;
      check("fair_rsp_valid", 64'(rsp_valid), 64'd1);
      check("fair_rsp_id", 64'(rsp_id), 64'(k % 4));
      check("fair_rsp_data", 64'(rsp_data), 64'(100 + k));
      check("fair_ready_resp", 64'(req_ready), 64'd0);
    end

    // Single request, reduction answers 1 six cycles after red_start
    tick();
    req_data[47:0] = 48'd8380418;
    req_q[22:0]    = 23'd8380417;
    rsp_ready      = 1'b0;
    req_valid      = 4'b0001;
    wait_grant(g);
    check("single_grant", 64'(g), 64'b0001);
    tick();
    req_valid = 4'b0000;
    check("single_start", 64'(red_start), 64'd1);
    check("single_data_in", 64'(red_data_in), 64'd8380418);
    check("single_q", 64'(red_q), 64'd8380417);
    tick();
    check("single_start_pulse", 64'(red_start), 64'd0);
    repeat (4) tick();
    tick();
    red_done     = 1'b1;
    red_data_out = 23'd1;
    #1;
    check("single_not_yet", 64'(rsp_valid), 64'd0);
    tick();
    red_done = 1'b0;
    check("single_rsp_valid", 64'(rsp_valid), 64'd1);
    check("single_rsp_id", 64'(rsp_id), 64'd0);
    check("single_rsp_data", 64'(rsp_data), 64'd1);
    check("single_rsp_err", 64'(rsp_err), 64'd0);
    check("single_red_q_hold", 64'(red_q), 64'd8380417);
    rsp_ready = 1'b1;
    tick();
    check("single_rsp_drop", 64'(rsp_valid), 64'd0);

    // Backpressure: ptr=1, requesters 2 and 3 waiting, rsp_ready low 5 cycles
    rsp_ready = 1'b0;
    req_valid = 4'b1100;
    wait_grant(g);
    check("bp_grant", 64'(g), 64'b0100);
    tick();
    check("bp_start", 64'(red_start), 64'd1);
    tick();
    red_done     = 1'b1;
    red_data_out = 23'h1234;
    tick();
    red_done     = 1'b0;
    red_data_out = 23'h7FFFFF;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_valid", 64'(rsp_valid), 64'd1);
      check("bp_fields", 64'({rsp_id, rsp_data, rsp_err}), 64'({2'd2, 23'h1234, 1'b0}));
      check("bp_ready_low", 64'(req_ready), 64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_ready_handshake_cycle", 64'(req_ready), 64'd0);
    tick();
    check("bp_rsp_drop", 64'(rsp_valid), 64'd0);
    wait_grant(g);
    check("bp_next_grant", 64'(g), 64'b1000);

    // Timeout: requester 3 never gets red_done
    tick();
    req_valid = 4'b0000;
    check("to_start", 64'(red_start), 64'd1);
    n = 0;
    while (!rsp_valid && n < 100) begin
      tick();
      n++;
    end
    check("to_latency", 64'(n), 64'd64);
    check("to_err", 64'(rsp_err), 64'd1);
    check("to_data", 64'(rsp_data), 64'd0);
    check("to_id", 64'(rsp_id), 64'd3);
    tick();
    check("to_rsp_drop", 64'(rsp_valid), 64'd0);

    // Reset three cycles after red_start abandons the transaction
    req_valid = 4'b0001;
    wait_grant(g);
    check("rw_grant", 64'(g), 64'b0001);
    tick();
    req_valid = 4'b0000;
    check("rw_start", 64'(red_start), 64'd1);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check_all_zero("rw_reset");
    tick();
    tick();
    check_all_zero("rw_reset_hold");
    rst_n     = 1'b1;
    req_valid = 4'b0100;
    wait_grant(g);
    check("rw_first_grant", 64'(g), 64'b0100);
    check("rw_no_rsp", 64'(rsp_valid), 64'd0);
    tick();
    req_valid = 4'b0000;
    check("rw_data_in", 64'(red_data_in), 64'h1002);
    tick();
    red_done     = 1'b1;
    red_data_out = 23'h77;
    tick();
    red_done = 1'b0;
    check("rw_rsp", 64'({rsp_valid, rsp_id, rsp_data, rsp_err}), 64'({1'b1, 2'd2, 23'h77, 1'b0}));
    tick();

    // Stray red_done in IDLE is ignored
    red_done     = 1'b1;
    red_data_out = 23'h55;
    tick();
    red_done = 1'b0;
    check("stray_valid", 64'(rsp_valid), 64'd0);
    check("stray_data", 64'(rsp_data), 64'h77);
    check("stray_start", 64'(red_start), 64'd0);
    req_valid = 4'b0010;
    #1;
    check("stray_still_idle", 64'(req_ready), 64'b0010);
    req_valid = 4'b0000;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
